// File: rtl/exe_muldiv_if.sv
// Handshake and data bundle between the ID/EXE pipeline side and the
// iterative multiply/divide unit.
interface exe_muldiv_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs1_val_i;
   logic [XLEN-1:0] rs2_val_i;
   logic [4:0]      rd_addr_i;
   logic            kill_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;
   logic [4:0]      rd_addr_o;
   logic            rd_we_o;

   modport master (
      output start_i, op_i, rs1_val_i, rs2_val_i, rd_addr_i, kill_i,
      input  busy_o, done_o, result_o, rd_addr_o, rd_we_o
   );

   modport slave (
      input  start_i, op_i, rs1_val_i, rs2_val_i, rd_addr_i, kill_i,
      output busy_o, done_o, result_o, rd_addr_o, rd_we_o
   );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide: one shared shift/add-subtract datapath,
// one product/quotient bit per cycle, sign fix-up applied in the DONE cycle.
module exe_muldiv #(
   parameter int XLEN  = 32,
   parameter int STEPS = XLEN
) (
   input  logic        clk_i,
   input  logic        rst_i,
   exe_muldiv_if.slave io
);
   localparam int CW = $clog2(STEPS + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic            neg_q, neg_d;

   // Operand conditioning at start: magnitudes and final sign
   logic            sgn1, sgn2, s1, s2, neg_n, div0, ovf;
   logic [XLEN-1:0] m1, m2;

   always_comb begin
      sgn1  = (io.op_i == 3'd1) | (io.op_i == 3'd2) | (io.op_i == 3'd4) | (io.op_i == 3'd6);
      sgn2  = (io.op_i == 3'd1) | (io.op_i == 3'd4) | (io.op_i == 3'd6);
      s1    = sgn1 & io.rs1_val_i[XLEN-1];
      s2    = sgn2 & io.rs2_val_i[XLEN-1];
      m1    = s1 ? (~io.rs1_val_i + 1'b1) : io.rs1_val_i;
      m2    = s2 ? (~io.rs2_val_i + 1'b1) : io.rs2_val_i;
      neg_n = 1'b0;
      case (io.op_i)
         3'd1, 3'd2, 3'd4: neg_n = s1 ^ s2;
         3'd6:             neg_n = s1;
         default:          neg_n = 1'b0;
      endcase
      div0 = io.op_i[2] & (io.rs2_val_i == '0);
      ovf  = ((io.op_i == 3'd4) | (io.op_i == 3'd6)) &
             (io.rs1_val_i == {1'b1, {(XLEN-1){1'b0}}}) & (io.rs2_val_i == '1);
   end

   // Shared adder: hi+b for multiply, {hi,lo_msb}-b for divide (carry out = no borrow)
   logic              is_div;
   logic [XLEN:0]     opa, opb;
   logic [XLEN+1:0]   sum;

   assign is_div = (state_q == S_DIV);
   assign opa    = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
   assign opb    = is_div ? ~{1'b0, b_q} : (lo_q[0] ? {1'b0, b_q} : '0);
   assign sum    = {1'b0, opa} + {1'b0, opb} + {{(XLEN+1){1'b0}}, is_div};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      op_d    = op_q;
      rd_d    = rd_q;
      neg_d   = neg_q;
      case (state_q)
         S_IDLE: begin
            if (io.start_i && !io.kill_i) begin
               op_d  = io.op_i;
               rd_d  = io.rd_addr_i;
               b_d   = m2;
               hi_d  = '0;
               lo_d  = m1;
               cnt_d = CW'(STEPS);
               neg_d = neg_n;
               // Special cases preload quotient (lo) and remainder (hi) directly
               if (div0) begin
                  hi_d    = io.rs1_val_i;
                  lo_d    = '1;
                  neg_d   = 1'b0;
                  state_d = S_DONE;
               end else if (ovf) begin
                  hi_d    = '0;
                  lo_d    = {1'b1, {(XLEN-1){1'b0}}};
                  neg_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  state_d = io.op_i[2] ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
            hi_d  = sum[XLEN:1];
            lo_d  = {sum[0], lo_q[XLEN-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DIV: begin
            hi_d  = sum[XLEN+1] ? sum[XLEN-1:0] : opa[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], sum[XLEN+1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (io.kill_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         neg_q   <= neg_d;
      end
   end

   // Sign fix-up and result select
   logic [2*XLEN-1:0] prod, prod_n;
   logic [XLEN-1:0]   dv, dv_n, res;
   logic              done;

   always_comb begin
      prod   = {hi_q, lo_q};
      prod_n = neg_q ? (~prod + 1'b1) : prod;
      dv     = op_q[1] ? hi_q : lo_q;
      dv_n   = neg_q ? (~dv + 1'b1) : dv;
      if (op_q[2])             res = dv_n;
      else if (op_q[1:0] == 0) res = prod_n[XLEN-1:0];
      else                     res = prod_n[2*XLEN-1:XLEN];
   end

   assign done         = (state_q == S_DONE) & ~io.kill_i;
   assign io.done_o    = done;
   assign io.result_o  = done ? res : '0;
   assign io.rd_addr_o = done ? rd_q : '0;
   assign io.rd_we_o   = done & (rd_q != 5'd0);
   assign io.busy_o    = ~io.kill_i & ((io.start_i & (state_q == S_IDLE)) |
                                       (state_q == S_MUL) | (state_q == S_DIV));
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: reference model feeds a scoreboard queue,
// popped and compared on each done pulse, with latency and stall checks.
module tb_exe_muldiv;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   exe_muldiv_if #(.XLEN(32)) bus ();
   exe_muldiv #(.XLEN(32), .STEPS(32)) dut (.clk_i(clk), .rst_i(rst), .io(bus.slave));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        we;
      int          lat;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sbv, p;
      logic [63:0]        ua, ub, up;
      logic signed [31:0] a32, b32;
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      a32 = $signed(a);
      b32 = $signed(b);
      case (op)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(a32 / b32);
         end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(a32 % b32);
         end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // Starts at a negedge; returns at the negedge of the done cycle with start_i still high
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input bit b2b, input string tag);
      exp_t e;
      int   k;
      bit   seen, busy_bad;
      e.res = model(op, a, b); e.rd = rd; e.we = (rd != 5'd0); e.lat = lat;
      sb.push_back(e);
      bus.start_i = 1'b1; bus.op_i = op; bus.rs1_val_i = a; bus.rs2_val_i = b; bus.rd_addr_i = rd;
      if (b2b) begin
         #1 chk({tag, ".busy_in_done"}, 32'(bus.busy_o), 32'd0);
         @(negedge clk);
      end
      #1 chk({tag, ".busy_T"}, 32'(bus.busy_o), 32'd1);
      k = 0; seen = 1'b0; busy_bad = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            bus.rs1_val_i = ~a;
            bus.rs2_val_i = b ^ 32'h5A5A_0001;
         end
         if (bus.done_o === 1'b1) seen = 1'b1;
         else if (bus.busy_o !== 1'b1 || bus.result_o !== 32'd0 || bus.rd_we_o !== 1'b0) busy_bad = 1'b1;
      end
      chk({tag, ".stall"}, 32'(busy_bad), 32'd0);
      chk({tag, ".latency"}, 32'(k), 32'(lat));
      e = sb.pop_front();
      if (seen) begin
         chk({tag, ".result"}, bus.result_o, e.res);
         chk({tag, ".rd_addr"}, 32'(bus.rd_addr_o), 32'(e.rd));
         chk({tag, ".rd_we"}, 32'(bus.rd_we_o), 32'(e.we));
         chk({tag, ".busy_done"}, 32'(bus.busy_o), 32'd0);
      end
   endtask

   task automatic gap();
      bus.start_i = 1'b0;
      @(negedge clk);
      #1 chk("gap.done", 32'(bus.done_o), 32'd0);
      chk("gap.busy", 32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      int dones;
      rst = 1'b1;
      bus.start_i = 1'b0; bus.op_i = '0; bus.rs1_val_i = '0; bus.rs2_val_i = '0;
      bus.rd_addr_i = '0; bus.kill_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(bus.busy_o), 32'd0);
      chk("rst.done", 32'(bus.done_o), 32'd0);
      chk("rst.result", bus.result_o, 32'd0);
      chk("rst.rd_we", 32'(bus.rd_we_o), 32'd0);
      chk("rst.rd_addr", 32'(bus.rd_addr_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 1'b0, "mul");
      chk("mul.const", bus.result_o, 32'hFFFF_FFEB);
      gap();
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 33, 1'b0, "mulh");   gap();
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 33, 1'b0, "mulhu");  gap();
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 33, 1'b0, "mulhsu"); gap();
      run_op(3'd1, 32'h1234_5678, 32'hF000_00F1, 5'd9, 33, 1'b0, "mulh2");  gap();
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 33, 1'b0, "div");
      chk("div.const", bus.result_o, 32'hFFFF_FFFD);
      gap();
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 33, 1'b0, "rem");      gap();
      run_op(3'd5, 32'd100, 32'd7, 5'd7, 33, 1'b0, "divu");           gap();
      run_op(3'd7, 32'd100, 32'd7, 5'd8, 33, 1'b0, "remu");           gap();
      run_op(3'd5, 32'hFFFF_FFF0, 32'h8000_0001, 5'd10, 33, 1'b0, "divu_big"); gap();
      run_op(3'd7, 32'hFFFF_FFF0, 32'h8000_0001, 5'd11, 33, 1'b0, "remu_big"); gap();
      run_op(3'd4, 32'h0000_1234, 32'd0, 5'd12, 1, 1'b0, "div0");     gap();
      run_op(3'd6, 32'h0000_1234, 32'd0, 5'd13, 1, 1'b0, "rem0");     gap();
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 1'b0, "div_ovf"); gap();
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 1'b0, "rem_ovf"); gap();

      // Flush a DIV in flight at T+10
      bus.start_i = 1'b1; bus.op_i = 3'd4; bus.rs1_val_i = 32'd1000; bus.rs2_val_i = 32'd7; bus.rd_addr_i = 5'd3;
      repeat (10) @(negedge clk);
      bus.kill_i = 1'b1; bus.start_i = 1'b0;
      #1 chk("kill.busy", 32'(bus.busy_o), 32'd0);
      chk("kill.done", 32'(bus.done_o), 32'd0);
      @(negedge clk);
      bus.kill_i = 1'b0;
      #1 chk("kill.idle_busy", 32'(bus.busy_o), 32'd0);
      dones = 0;
      repeat (40) begin @(negedge clk); if (bus.done_o) dones++; end
      chk("kill.no_done", 32'(dones), 32'd0);

      // Reset mid-MUL
      bus.start_i = 1'b1; bus.op_i = 3'd0; bus.rs1_val_i = 32'd11; bus.rs2_val_i = 32'd13; bus.rd_addr_i = 5'd20;
      repeat (10) @(negedge clk);
      rst = 1'b1; bus.start_i = 1'b0;
      #1 chk("rstmid.busy", 32'(bus.busy_o), 32'd0);
      chk("rstmid.result", bus.result_o, 32'd0);
      chk("rstmid.rd_we", 32'(bus.rd_we_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (40) begin @(negedge clk); if (bus.done_o) dones++; end
      chk("rstmid.no_done", 32'(dones), 32'd0);
      run_op(3'd0, 32'd11, 32'd13, 5'd20, 33, 1'b0, "mul_after_rst"); gap();

      // Back-to-back MULs to x0
      run_op(3'd0, 32'd5, 32'd6, 5'd0, 33, 1'b0, "b2b_a");
      run_op(3'd0, 32'hFFFF_FFFF, 32'd9, 5'd0, 33, 1'b1, "b2b_b");
      gap();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
